// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   PC_N_DEFAULT            default PC width in bits
//   PC_RESET_VECTOR_DEFAULT PC value after reset
//   PC_TRAP_VECTOR_DEFAULT  PC value after a stack fault (trap builds only)
//   pc_op_t                 operation chosen by the priority encoder each cycle
package pc_pkg;

    localparam int          PC_N_DEFAULT            = 16;
    localparam logic [15:0] PC_RESET_VECTOR_DEFAULT = 16'h0080;
    localparam logic [15:0] PC_TRAP_VECTOR_DEFAULT  = 16'h0001;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_CALL,
        PC_RET,
        PC_TRAP
    } pc_op_t;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address stack (LIFO) of DEPTH entries, N bits each.
// Ports:
//   Clock, Reset   rising-edge clock, asynchronous active-high reset
//   push, din      write din at the next free slot and grow the stack
//   pop            shrink the stack by one entry
//   top            most recently pushed entry (undefined when empty)
//   sp_count       number of valid entries, 0..DEPTH
// The parent never asserts push and pop together and never pushes when
// full or pops when empty.
module pc_ras
    import pc_pkg::*;
#(
    parameter int N     = PC_N_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [N-1:0]             din,
    output logic [N-1:0]             top,
    output logic [$clog2(DEPTH):0]   sp_count
);

    localparam int AW = $clog2(DEPTH);

    logic [N-1:0] mem [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    // The low AW bits of sp_count address the next free slot; the entry
    // below it is the top. At sp_count == DEPTH the low bits are zero and
    // the subtraction wraps to DEPTH-1, which is the correct top.
    assign wr_idx = sp_count[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);
    assign top    = mem[rd_idx];

    // Storage carries no reset: contents are meaningless until pushed.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sp_count <= '0;
        end else if (push) begin
            sp_count <= sp_count + 1'b1;
        end else if (pop) begin
            sp_count <= sp_count - 1'b1;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with branch, call and return support.
// Ports:
//   Clock, Reset     rising-edge clock, asynchronous active-high reset
//   R                branch/call target
//   Rin, inc         branch load / sequential increment
//   call, ret        subroutine call (push Q+1, load R) / return (pop to Q)
//   Q                current PC
//   sp_count         valid return-stack entries
//   stack_full/empty decodes of sp_count
//   fault            sticky stack overflow/underflow flag
// Handshake: none. Each request input is sampled on every rising edge and
// consumed in that cycle; priority is ret > call > Rin > inc > hold.
// Build option: define PC_STACK_TRAP_EN to send stack overflow/underflow
// to TRAP_VECTOR and raise fault. Without it, an overflowing call drops
// its push but still jumps, an underflowing ret acts as inc, and fault
// stays 0.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int         N            = PC_N_DEFAULT,
    parameter logic [N-1:0] RESET_VECTOR = N'(PC_RESET_VECTOR_DEFAULT),
    parameter int         DEPTH        = 4,
    parameter logic [N-1:0] TRAP_VECTOR  = N'(PC_TRAP_VECTOR_DEFAULT)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [N-1:0]           R,
    input  logic                   Rin,
    input  logic                   inc,
    input  logic                   call,
    input  logic                   ret,
    output logic [N-1:0]           Q,
    output logic [$clog2(DEPTH):0] sp_count,
    output logic                   stack_full,
    output logic                   stack_empty,
    output logic                   fault
);

    localparam int SPW = $clog2(DEPTH) + 1;

    pc_op_t       op;
    logic [N-1:0] q_plus1;
    logic [N-1:0] ras_top;
    logic         push;
    logic         pop;

    assign q_plus1     = Q + N'(1);
    assign stack_full  = (sp_count == SPW'(DEPTH));
    assign stack_empty = (sp_count == '0);

    // Priority encoder: resolves request priority and stack faults so the
    // stack only ever sees a legal push or a legal pop.
    always_comb begin
        op = PC_HOLD;
        if (ret) begin
            if (!stack_empty) begin
                op = PC_RET;
            end else begin
`ifdef PC_STACK_TRAP_EN
                op = PC_TRAP;
`else
                op = PC_INC;
`endif
            end
        end else if (call) begin
            if (!stack_full) begin
                op = PC_CALL;
            end else begin
`ifdef PC_STACK_TRAP_EN
                op = PC_TRAP;
`else
                op = PC_LOAD;
`endif
            end
        end else if (Rin) begin
            op = PC_LOAD;
        end else if (inc) begin
            op = PC_INC;
        end
    end

    assign push = (op == PC_CALL);
    assign pop  = (op == PC_RET);

    pc_ras #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_ras (
        .Clock    (Clock),
        .Reset    (Reset),
        .push     (push),
        .pop      (pop),
        .din      (q_plus1),
        .top      (ras_top),
        .sp_count (sp_count)
    );

    // PC_TRAP cannot be selected in the silent build; its arm is harmless.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Q <= RESET_VECTOR;
        end else begin
            case (op)
                PC_INC:           Q <= q_plus1;
                PC_LOAD, PC_CALL: Q <= R;
                PC_RET:           Q <= ras_top;
                PC_TRAP:          Q <= TRAP_VECTOR;
                default:          Q <= Q;
            endcase
        end
    end

`ifdef PC_STACK_TRAP_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            fault <= 1'b0;
        end else if (op == PC_TRAP) begin
            fault <= 1'b1;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

  logic        Clock;
  logic        Reset;
  logic [15:0] R;
  logic        Rin;
  logic        inc;
  logic        call;
  logic        ret;
  logic [15:0] Q;
  logic [2:0]  sp_count;
  logic        stack_full;
  logic        stack_empty;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: PC value, return-address stack as a queue, fault flag.
  logic [15:0] exp_q[$];
  logic [15:0] m_pc;
  logic        m_fault;

  pc_stack_unit #(
    .N(16), .RESET_VECTOR(16'h0080), .DEPTH(4), .TRAP_VECTOR(16'h0001)
  ) dut (
    .Clock(Clock), .Reset(Reset), .R(R), .Rin(Rin), .inc(inc),
    .call(call), .ret(ret), .Q(Q), .sp_count(sp_count),
    .stack_full(stack_full), .stack_empty(stack_empty), .fault(fault)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- model ----------------
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_pc = 16'h0080;
      exp_q.delete();
      m_fault = 1'b0;
    end else if (ret) begin
      if (exp_q.size() > 0) begin
        m_pc = exp_q.pop_back();
      end else begin
`ifdef PC_STACK_TRAP_EN
        m_pc = 16'h0001;
        m_fault = 1'b1;
`else
        m_pc = m_pc + 16'd1;
`endif
      end
    end else if (call) begin
      if (exp_q.size() < 4) begin
        exp_q.push_back(m_pc + 16'd1);
        m_pc = R;
      end else begin
`ifdef PC_STACK_TRAP_EN
        m_pc = 16'h0001;
        m_fault = 1'b1;
`else
        m_pc = R;
`endif
      end
    end else if (Rin) begin
      m_pc = R;
    end else if (inc) begin
      m_pc = m_pc + 16'd1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (Reset === 1'b0) begin
      check("model_q", 32'(Q), 32'(m_pc));
      check("model_sp", 32'(sp_count), 32'(exp_q.size()));
      check("model_full", 32'(stack_full), 32'(exp_q.size() == 4));
      check("model_empty", 32'(stack_empty), 32'(exp_q.size() == 0));
      check("model_fault", 32'(fault), 32'(m_fault));
    end
  end

  // ---------------- driver ----------------
  // Called just after a falling edge; returns at the next falling edge,
  // so the request is sampled by exactly one rising edge.
  task automatic drive(input logic d_ret, input logic d_call,
                       input logic d_rin, input logic d_inc,
                       input logic [15:0] d_r);
    ret = d_ret; call = d_call; Rin = d_rin; inc = d_inc; R = d_r;
    @(negedge Clock);
    ret = 1'b0; call = 1'b0; Rin = 1'b0; inc = 1'b0; R = 16'h0000;
  endtask

  task automatic do_rin(input logic [15:0] t);  drive(0, 0, 1, 0, t); endtask
  task automatic do_call(input logic [15:0] t); drive(0, 1, 0, 0, t); endtask
  task automatic do_ret();                     drive(1, 0, 0, 0, 16'h0); endtask
  task automatic do_inc();                     drive(0, 0, 0, 1, 16'h0); endtask

  // Pulse Reset entirely between edges and check the immediate effect.
  task automatic reset_pulse();
    #2 Reset = 1'b1;
    #1;
    check("rst_q", 32'(Q), 32'h0080);
    check("rst_sp", 32'(sp_count), 32'd0);
    check("rst_empty", 32'(stack_empty), 32'd1);
    #1 Reset = 1'b0;
  endtask

  logic [15:0] targets [4];
  logic [15:0] returns [4];

  initial begin
    Reset = 1'b1; R = 16'h0; Rin = 0; inc = 0; call = 0; ret = 0;
    targets[0] = 16'h1000; targets[1] = 16'h2000;
    targets[2] = 16'h3000; targets[3] = 16'h4000;
    returns[0] = 16'h3001; returns[1] = 16'h2001;
    returns[2] = 16'h1001; returns[3] = 16'h0081;
    repeat (2) @(negedge Clock);
    #2 Reset = 1'b0;

    // Reset state
    check("init_q", 32'(Q), 32'h0080);
    check("init_sp", 32'(sp_count), 32'd0);
    check("init_empty", 32'(stack_empty), 32'd1);
    check("init_full", 32'(stack_full), 32'd0);
    check("init_fault", 32'(fault), 32'd0);

    // 1. sequential increment
    do_inc(); check("inc1", 32'(Q), 32'h0081);
    do_inc(); check("inc2", 32'(Q), 32'h0082);
    do_inc(); check("inc3", 32'(Q), 32'h0083);
    check("inc_empty", 32'(stack_empty), 32'd1);

    // 2. call then immediate ret
    do_rin(16'h0090); check("rin", 32'(Q), 32'h0090);
    do_call(16'h0200);
    check("call_q", 32'(Q), 32'h0200);
    check("call_sp", 32'(sp_count), 32'd1);
    do_ret();
    check("ret_q", 32'(Q), 32'h0091);
    check("ret_sp", 32'(sp_count), 32'd0);

    // 3. four nested calls, four returns
    do_rin(16'h0080);
    for (int i = 0; i < 4; i++) begin
      do_call(targets[i]);
      check("nest_call_q", 32'(Q), 32'(targets[i]));
    end
    check("nest_full", 32'(stack_full), 32'd1);
    check("nest_sp", 32'(sp_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      do_ret();
      check("nest_ret_q", 32'(Q), 32'(returns[i]));
    end
    check("nest_empty", 32'(stack_empty), 32'd1);

    // 4. overflow
    do_rin(16'h0080);
    for (int i = 0; i < 4; i++) do_call(targets[i]);
    do_call(16'h5000);
`ifdef PC_STACK_TRAP_EN
    check("ovf_q", 32'(Q), 32'h0001);
    check("ovf_fault", 32'(fault), 32'd1);
`else
    check("ovf_q", 32'(Q), 32'h5000);
    check("ovf_fault", 32'(fault), 32'd0);
`endif
    check("ovf_sp", 32'(sp_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      do_ret();
      check("ovf_ret_q", 32'(Q), 32'(returns[i]));
    end

    // 5. underflow
    do_rin(16'h00A0);
    do_ret();
`ifdef PC_STACK_TRAP_EN
    check("udf_q", 32'(Q), 32'h0001);
    check("udf_fault", 32'(fault), 32'd1);
    do_inc();
    check("fault_sticky", 32'(fault), 32'd1);
`else
    check("udf_q", 32'(Q), 32'h00A1);
    check("udf_fault", 32'(fault), 32'd0);
`endif
    check("udf_sp", 32'(sp_count), 32'd0);
    reset_pulse();
    check("fault_cleared", 32'(fault), 32'd0);

    // 6. priority and boundaries
    do_rin(16'h0122);
    do_call(16'h0500);
    drive(1, 0, 1, 1, 16'h0777);
    check("prio_ret", 32'(Q), 32'h0123);
    check("prio_sp", 32'(sp_count), 32'd0);
    do_rin(16'hFFFF);
    do_inc();
    check("wrap_inc", 32'(Q), 32'h0000);
    do_rin(16'hFFFF);
    do_call(16'h0300);
    do_ret();
    check("wrap_push", 32'(Q), 32'h0000);
    drive(0, 1, 1, 1, 16'h0400);
    check("prio_call_q", 32'(Q), 32'h0400);
    check("prio_call_sp", 32'(sp_count), 32'd1);

    // Reset between edges with a non-empty stack
    reset_pulse();
    do_inc();
    check("post_rst_inc", 32'(Q), 32'h0081);

    @(negedge Clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
